// File: rtl/truth_table_scanner.sv
// Truth-table extractor: sweeps all 2^N input combinations through an external function,
// builds the minterm mask/count, then streams term indices. Define SCAN_MAXTERM_EN to allow maxterm streaming.
module truth_table_scanner #(
   parameter int N      = 4,
   parameter int SETTLE = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             sel_max,
   input  logic             f_in,
   output logic [N-1:0]     vars,
   output logic             busy,
   output logic             done,
   output logic [2**N-1:0]  mask,
   output logic [N:0]       count,
   output logic [N-1:0]     idx,
   output logic             idx_valid,
   input  logic             idx_ready
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE);

   typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      vars_q, vars_d;
   logic [3:0]        settle_q, settle_d;
   logic [2**N-1:0]   mask_q, mask_d;
   logic [N:0]        count_q, count_d;
   logic [N:0]        ptr_q, ptr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              target;
   logic              match;

`ifdef SCAN_MAXTERM_EN
   logic              sel_max_q, sel_max_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) sel_max_q <= 1'b0;
      else       sel_max_q <= sel_max_d;
   end

   always_comb begin
      sel_max_d = sel_max_q;
      if (state_q == IDLE && start) sel_max_d = sel_max;
   end

   assign target = ~sel_max_q;
`else
   logic              unused_sel_max;

   assign unused_sel_max = sel_max;
   assign target         = 1'b1;
`endif

   // The extra pointer bit marks "past the last index", giving one closing cycle before done.
   assign match = (state_q == EMIT) && !ptr_q[N] && (mask_q[ptr_q[N-1:0]] == target);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         vars_q   <= '0;
         settle_q <= '0;
         mask_q   <= '0;
         count_q  <= '0;
         ptr_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vars_q   <= vars_d;
         settle_q <= settle_d;
         mask_q   <= mask_d;
         count_q  <= count_d;
         ptr_q    <= ptr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      vars_d   = vars_q;
      settle_d = settle_q;
      mask_d   = mask_q;
      count_d  = count_q;
      ptr_d    = ptr_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = SCAN;
               vars_d   = '0;
               settle_d = '0;
               mask_d   = '0;
               count_d  = '0;
               busy_d   = 1'b1;
            end
         end
         SCAN: begin
            if (settle_q == SETTLE_LAST) begin
               mask_d[vars_q] = f_in;
               count_d        = count_q + (N+1)'(f_in);
               vars_d         = vars_q + 1'b1;
               settle_d       = '0;
               if (vars_q == {N{1'b1}}) begin
                  state_d = EMIT;
                  ptr_d   = '0;
               end
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         EMIT: begin
            if (ptr_q[N]) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               ptr_d   = '0;
            end else if (!match || idx_ready) begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign vars      = vars_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign mask      = mask_q;
   assign count     = count_q;
   assign idx_valid = match;
   assign idx       = match ? ptr_q[N-1:0] : '0;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: the function under test is a truth table held in the bench,
// expected term lists are pushed at start and popped by an independent monitor.
module tb_truth_table_scanner;

   localparam int N     = 4;
   localparam int DEPTH = 16;
   localparam int LAT   = 49;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic              sel_max;
   logic              f_in;
   logic [N-1:0]      vars;
   logic              busy;
   logic              done;
   logic [DEPTH-1:0]  mask;
   logic [N:0]        count;
   logic [N-1:0]      idx;
   logic              idx_valid;
   logic              idx_ready;
   logic [DEPTH-1:0]  funcTbl = '0;

   int nChecks   = 0;
   int nErrors   = 0;
   int cycle     = 0;
   int readyMode = 0;
   int stallLeft = 0;
   int stall5    = 0;
   int doneCnt   = 0;
   int doneCycle = 0;
   int expQ[$];
   logic prevStall = 1'b0;

   truth_table_scanner #(.N(N), .SETTLE(1)) dut (
      .clock(clock), .reset(reset), .start(start), .sel_max(sel_max), .f_in(f_in),
      .vars(vars), .busy(busy), .done(done), .mask(mask), .count(count),
      .idx(idx), .idx_valid(idx_valid), .idx_ready(idx_ready)
   );

   // The function under test is a plain lookup on the driven combination.
   assign f_in = funcTbl[vars];

   always #5 clock = ~clock;

   initial forever begin
      @(posedge clock);
      cycle++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int popCount(input logic [DEPTH-1:0] fn);
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(fn[i]);
      return n;
   endfunction

   // Consumer model: always ready, random ready, or a five-cycle stall on index 5.
   initial begin
      idx_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         case (readyMode)
            1: idx_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (idx_valid && idx == 4'd5 && stallLeft > 0) begin
                  idx_ready = 1'b0;
                  stallLeft--;
               end else begin
                  idx_ready = 1'b1;
               end
            end
            default: idx_ready = 1'b1;
         endcase
      end
   end

   // Monitor: every presented index must be the scoreboard head; a stalled index must stay valid.
   initial forever begin
      @(negedge clock);
      if (reset) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) checkOutput("hold_valid", 32'(idx_valid), 32'd1);
         if (idx_valid) begin
            if (expQ.size() == 0) begin
               nChecks++;
               nErrors++;
               $display("[TB] FAIL spurious_idx: got %0d expected no output", idx);
            end else begin
               checkOutput("stream_idx", 32'(idx), 32'(expQ[0]));
               if (idx_ready) void'(expQ.pop_front());
            end
            if (!idx_ready && idx == 4'd5) stall5++;
         end
         prevStall = idx_valid && !idx_ready;
         if (done) begin
            doneCnt++;
            doneCycle = cycle;
         end
      end
   end

   // One complete scan: build expectations from the truth table, start, wait for done, check results.
   task automatic applyStimulus(input logic [DEPTH-1:0] fn, input logic sm, input int mode, input bit pokeStart);
      logic tgt;
      int   k;
      int   expCount;
      funcTbl   = fn;
      readyMode = mode;
      stallLeft = (mode == 2) ? 5 : 0;
      stall5    = 0;
      doneCnt   = 0;
`ifdef SCAN_MAXTERM_EN
      tgt = ~sm;
`else
      tgt = 1'b1;
`endif
      expQ.delete();
      for (int i = 0; i < DEPTH; i++) if (fn[i] == tgt) expQ.push_back(i);
      expCount = popCount(fn);
      @(negedge clock);
      start   = 1'b1;
      sel_max = sm;
      @(posedge clock);
      #1;
      k     = cycle;
      start = 1'b0;
      checkOutput("busy_at_start", 32'(busy), 32'd1);
      checkOutput("vars_at_start", 32'(vars), 32'd0);
      for (int c = 0; c < 2000 && doneCnt == 0; c++) begin
         @(negedge clock);
         #1;
         if (c == 10) begin
            sel_max = ~sm;
            if (pokeStart) start = 1'b1;
         end
         if (c == 11) start = 1'b0;
      end
      if (doneCnt == 0) begin
         nChecks++;
         nErrors++;
         $display("[TB] FAIL done_timeout: got no done expected done within 2000 cycles");
      end else begin
         if (mode == 0) checkOutput("done_latency", 32'(doneCycle - k), 32'(LAT));
         else checkOutput("done_latency_min", 32'(doneCycle - k >= LAT), 32'd1);
         checkOutput("mask", 32'(mask), 32'(fn));
         checkOutput("count", 32'(count), 32'(expCount));
         checkOutput("busy_at_done", 32'(busy), 32'd0);
         checkOutput("idx_valid_at_done", 32'(idx_valid), 32'd0);
         checkOutput("stream_drained", 32'(expQ.size()), 32'd0);
         if (mode == 2) checkOutput("stall_cycles", 32'(stall5), 32'd5);
         @(negedge clock);
         #1;
         checkOutput("done_pulse_width", 32'(done), 32'd0);
         repeat (3) @(negedge clock);
         checkOutput("mask_held", 32'(mask), 32'(fn));
         checkOutput("count_held", 32'(count), 32'(expCount));
      end
      expQ.delete();
      readyMode = 0;
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      sel_max = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("reset_vars", 32'(vars), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_idx_valid", 32'(idx_valid), 32'd0);
      checkOutput("reset_mask", 32'(mask), 32'd0);
      reset = 1'b0;

      applyStimulus(16'h22A5, 1'b0, 0, 1'b0);
`ifdef SCAN_MAXTERM_EN
      applyStimulus(16'h22A5, 1'b1, 0, 1'b0);
`endif
      applyStimulus(16'h0000, 1'b0, 0, 1'b0);
      applyStimulus(16'hFFFF, 1'b0, 0, 1'b0);
      applyStimulus(16'h22A5, 1'b0, 2, 1'b0);

      // Mid-scan reset at vars=9, then a full rescan.
      funcTbl = 16'h22A5;
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      for (int c = 0; c < 200 && vars != 4'd9; c++) @(negedge clock);
      if (vars != 4'd9) begin
         nChecks++;
         nErrors++;
         $display("[TB] FAIL vars9_timeout: got %0d expected 9", vars);
      end
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset_vars", 32'(vars), 32'd0);
      checkOutput("midreset_mask", 32'(mask), 32'd0);
      checkOutput("midreset_count", 32'(count), 32'd0);
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_done", 32'(done), 32'd0);
      checkOutput("midreset_idx", 32'(idx), 32'd0);
      checkOutput("midreset_idx_valid", 32'(idx_valid), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(16'h22A5, 1'b0, 0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         applyStimulus(16'($urandom), 1'($urandom_range(0, 1)), 1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
